l2_set_read: RTL and testbench
==============================

L2_SET_READ -- requirements
Module: l2_set_read

Interface
REQ-001 SHALL have parameter WAYS, default 4, number of L2 ways (power of 2, >=2).
REQ-002 SHALL have parameter WORDS, default 4, words per line.
REQ-003 SHALL have parameter SET_BITS, default 8, set index width.
REQ-004 SHALL have parameter TAG_BITS, default 20, tag width.
REQ-005 SHALL have parameter STATE_BITS, default 3, per-word coherence state width; 0 is Invalid.
REQ-006 SHALL have port clk, input, 1, clock.
REQ-007 SHALL have port rst, input, 1, asynchronous active-low reset.
REQ-008 SHALL have ports req_valid/req_ready, input/output, 1 each, lookup request handshake.
REQ-009 SHALL have port req_set, input, SET_BITS, set to read.
REQ-010 SHALL have ports rd_en/rd_set, output, 1/SET_BITS, tag/state RAM read command; data returns exactly 1 cycle later.
REQ-011 SHALL have ports rd_tags/rd_states, input, WAYS*TAG_BITS / WAYS*WORDS*STATE_BITS, RAM read data.
REQ-012 SHALL have ports wr_en/wr_set/wr_way/wr_tag/wr_states, input, 1/SET_BITS/log2(WAYS)/TAG_BITS/WORDS*STATE_BITS, snooped RAM write.
REQ-013 SHALL have ports evict_adv/evict_set, input, 1/SET_BITS, advance round-robin victim of a set.
REQ-014 SHALL have ports tags_buf/states_buf, output, same widths as rd_tags/rd_states, registered set contents.
REQ-015 SHALL have port evict_way_buf, output, log2(WAYS), victim way of the buffered set.
REQ-016 SHALL have ports lookup_en/bufs_valid, output, 1 each, lookup-stage trigger and buffer-valid flag.
REQ-017 SHALL have port lookup_done, input, 1, downstream releases the buffers.

Function
REQ-018 SHALL implement FSM IDLE, WAIT, LOOKUP, HOLD; req_ready=1 only in IDLE.
REQ-019 IDLE: on req_valid, SHALL pulse rd_en with rd_set=req_set, latch set, go WAIT.
REQ-020 WAIT: SHALL capture rd_tags/rd_states into buffers, evict_way_buf=pointer[set], go LOOKUP.
REQ-021 LOOKUP: SHALL assert lookup_en for exactly one cycle, go HOLD; request-to-lookup_en latency 2 cycles.
REQ-022 bufs_valid SHALL be 1 in LOOKUP and HOLD, 0 otherwise.
REQ-023 HOLD: on lookup_done, SHALL go IDLE; lookup_done outside HOLD SHALL be ignored.
REQ-024 In LOOKUP/HOLD, wr_en with wr_set==latched set SHALL overwrite tags_buf/states_buf entry wr_way the next cycle.
REQ-025 SHALL keep a per-set pointer table (2^SET_BITS x log2(WAYS)); evict_adv increments pointer[evict_set] mod WAYS (WAYS-1 wraps to 0).
REQ-026 evict_adv to the set being captured in the same cycle: evict_way_buf SHALL take the pre-increment value.
REQ-027 evict_way_buf SHALL NOT change after capture until the next capture.
REQ-028 Outputs other than buffers SHALL be combinational from state only; buffers registered.

Reset
REQ-029 On rst low SHALL enter IDLE asynchronously, all outputs 0 except req_ready=1, pointer table all 0.
REQ-030 Reset mid-WAIT/HOLD SHALL discard the request; no lookup_en after release until a new request.

Configuration
REQ-031 Macro L2_SET_READ_BYPASS_EN SHALL select WAIT-cycle write handling.
REQ-032 Defined: wr_en matching latched set in WAIT SHALL be merged into the captured way (write wins over rd data).
REQ-033 Undefined: matching wr_en in WAIT SHALL discard read data, re-pulse rd_en same set, stay WAIT (one extra cycle per hit).

Verification
REQ-034 req_set=0x12, RAM returns tag 0xABCDE way 2 -> rd_en cycle 0, lookup_en cycle 2 only, tags_buf way2=0xABCDE, bufs_valid until lookup_done.
REQ-035 4x evict_adv set 5 then request set 5 -> evict_way_buf=0; 3x then request -> 3.
REQ-036 HOLD set 7, wr_en set 7 way 1 states all 0 -> states_buf way1 all 0 next cycle; wr_set 8 -> no change.
REQ-037 WAIT, matching wr way 3 tag 0x1 -> BYPASS_EN: way3=0x1, lookup_en cycle 2; else second rd_en, lookup_en cycle 3.
REQ-038 rst low in HOLD -> req_ready=1, bufs_valid=0, pointers 0, no lookup_en until new req.

Source files
------------

// File: rtl/l2_set_read_if.sv
// ---------------------------------------------------------------------------
// l2_set_read_if
// Bundles every signal of the L2 set-read stage except clock and reset.
//   req_valid/req_ready/req_set      : lookup request handshake
//   rd_en/rd_set, rd_tags/rd_states  : tag/state RAM read command and data
//                                      (data is valid one cycle after rd_en)
//   wr_en/wr_set/wr_way/wr_tag/
//   wr_states                        : snooped tag/state RAM write
//   evict_adv/evict_set              : advance a set's round-robin victim
//   tags_buf/states_buf              : registered contents of the read set
//   evict_way_buf                    : victim way of the buffered set
//   lookup_en/bufs_valid             : lookup trigger and buffer-valid flag
//   lookup_done                      : downstream releases the buffers
// The slave modport is the set-read block; master is whoever drives it.
// ---------------------------------------------------------------------------
interface l2_set_read_if #(
    parameter int WAYS       = 4,
    parameter int WORDS      = 4,
    parameter int SET_BITS   = 8,
    parameter int TAG_BITS   = 20,
    parameter int STATE_BITS = 3
);
    localparam int WAY_BITS = $clog2(WAYS);

    logic                                 req_valid;
    logic                                 req_ready;
    logic [SET_BITS-1:0]                  req_set;

    logic                                 rd_en;
    logic [SET_BITS-1:0]                  rd_set;
    logic [WAYS*TAG_BITS-1:0]             rd_tags;
    logic [WAYS*WORDS*STATE_BITS-1:0]     rd_states;

    logic                                 wr_en;
    logic [SET_BITS-1:0]                  wr_set;
    logic [WAY_BITS-1:0]                  wr_way;
    logic [TAG_BITS-1:0]                  wr_tag;
    logic [WORDS*STATE_BITS-1:0]          wr_states;

    logic                                 evict_adv;
    logic [SET_BITS-1:0]                  evict_set;

    logic [WAYS*TAG_BITS-1:0]             tags_buf;
    logic [WAYS*WORDS*STATE_BITS-1:0]     states_buf;
    logic [WAY_BITS-1:0]                  evict_way_buf;
    logic                                 lookup_en;
    logic                                 bufs_valid;
    logic                                 lookup_done;

    modport slave (
        input  req_valid, req_set,
        output req_ready,
        output rd_en, rd_set,
        input  rd_tags, rd_states,
        input  wr_en, wr_set, wr_way, wr_tag, wr_states,
        input  evict_adv, evict_set,
        output tags_buf, states_buf, evict_way_buf,
        output lookup_en, bufs_valid,
        input  lookup_done
    );

    modport master (
        output req_valid, req_set,
        input  req_ready,
        input  rd_en, rd_set,
        output rd_tags, rd_states,
        output wr_en, wr_set, wr_way, wr_tag, wr_states,
        output evict_adv, evict_set,
        input  tags_buf, states_buf, evict_way_buf,
        input  lookup_en, bufs_valid,
        output lookup_done
    );
endinterface

// File: rtl/l2_set_read.sv
// ---------------------------------------------------------------------------
// l2_set_read
// Reads one L2 set (all tags and per-word coherence states) from the tag/state
// RAM, holds it in registered buffers for the lookup stage, keeps those
// buffers coherent with snooped RAM writes, and supplies the round-robin
// victim way of the set from a per-set pointer table.
//
// Ports:
//   clk  : clock
//   rst  : asynchronous active-low reset
//   bus  : l2_set_read_if.slave (request, RAM read/write, evict, buffers)
//
// Build option:
//   L2_SET_READ_BYPASS_EN defined   : a write to the set being read that lands
//                                     in the RAM-data cycle is merged into the
//                                     captured data.
//   L2_SET_READ_BYPASS_EN undefined : such a write discards the RAM data and
//                                     the set is read again (one extra cycle).
// ---------------------------------------------------------------------------
module l2_set_read #(
    parameter int WAYS       = 4,
    parameter int WORDS      = 4,
    parameter int SET_BITS   = 8,
    parameter int TAG_BITS   = 20,
    parameter int STATE_BITS = 3
) (
    input  logic            clk,
    input  logic            rst,
    l2_set_read_if.slave    bus
);
    localparam int WAY_BITS  = $clog2(WAYS);
    localparam int SETS      = 1 << SET_BITS;
    localparam int LINE_BITS = WORDS * STATE_BITS;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_LOOKUP,
        ST_HOLD
    } state_e;

    state_e                          state_q, state_d;
    logic [SET_BITS-1:0]             set_q, set_d;
    logic [WAYS*TAG_BITS-1:0]        tagsBuf_q, tagsBuf_d;
    logic [WAYS*LINE_BITS-1:0]       statesBuf_q, statesBuf_d;
    logic [WAY_BITS-1:0]             evictWay_q, evictWay_d;
    logic [WAY_BITS-1:0]             ptr_q [SETS];
    logic                            wrHit;
    logic                            applyWrite;

    // A snooped write only matters when it targets the set we hold or are reading.
    assign wrHit = bus.wr_en && (bus.wr_set == set_q);

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic. lookup_done is only honoured in HOLD.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (bus.req_valid) state_d = ST_WAIT;
`ifdef L2_SET_READ_BYPASS_EN
            ST_WAIT:   state_d = ST_LOOKUP;
`else
            ST_WAIT:   if (!wrHit) state_d = ST_LOOKUP;
`endif
            ST_LOOKUP: state_d = ST_HOLD;
            ST_HOLD:   if (bus.lookup_done) state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Output logic. The RAM read command is gated by rst so every command
    // output is quiet while reset is held.
    always_comb begin
        bus.req_ready  = (state_q == ST_IDLE);
        bus.lookup_en  = (state_q == ST_LOOKUP);
        bus.bufs_valid = (state_q == ST_LOOKUP) || (state_q == ST_HOLD);
        bus.rd_en      = 1'b0;
        bus.rd_set     = '0;
        if (rst) begin
            if ((state_q == ST_IDLE) && bus.req_valid) begin
                bus.rd_en  = 1'b1;
                bus.rd_set = bus.req_set;
            end
`ifndef L2_SET_READ_BYPASS_EN
            else if ((state_q == ST_WAIT) && wrHit) begin
                bus.rd_en  = 1'b1;
                bus.rd_set = set_q;
            end
`endif
        end
    end

    // Buffer next-state: capture RAM data in WAIT, then patch in any write to
    // the held set. The victim is read from the pointer register before this
    // cycle's evict_adv lands, so a same-cycle advance yields the old value.
    always_comb begin
        set_d       = set_q;
        tagsBuf_d   = tagsBuf_q;
        statesBuf_d = statesBuf_q;
        evictWay_d  = evictWay_q;
        applyWrite  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.req_valid) set_d = bus.req_set;
            end
            ST_WAIT: begin
`ifdef L2_SET_READ_BYPASS_EN
                tagsBuf_d   = bus.rd_tags;
                statesBuf_d = bus.rd_states;
                evictWay_d  = ptr_q[set_q];
                applyWrite  = wrHit;
`else
                if (!wrHit) begin
                    tagsBuf_d   = bus.rd_tags;
                    statesBuf_d = bus.rd_states;
                    evictWay_d  = ptr_q[set_q];
                end
`endif
            end
            ST_LOOKUP, ST_HOLD: begin
                applyWrite = wrHit;
            end
            default: ;
        endcase
        if (applyWrite) begin
            for (int w = 0; w < WAYS; w++) begin
                if (WAY_BITS'(w) == bus.wr_way) begin
                    tagsBuf_d[w*TAG_BITS +: TAG_BITS]     = bus.wr_tag;
                    statesBuf_d[w*LINE_BITS +: LINE_BITS] = bus.wr_states;
                end
            end
        end
    end

    // Buffer registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            set_q       <= '0;
            tagsBuf_q   <= '0;
            statesBuf_q <= '0;
            evictWay_q  <= '0;
        end else begin
            set_q       <= set_d;
            tagsBuf_q   <= tagsBuf_d;
            statesBuf_q <= statesBuf_d;
            evictWay_q  <= evictWay_d;
        end
    end

    // Round-robin victim pointers; WAYS is a power of two so the natural
    // wrap of the WAY_BITS-wide add gives mod-WAYS behaviour.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < SETS; i++) ptr_q[i] <= '0;
        end else if (bus.evict_adv) begin
            ptr_q[bus.evict_set] <= ptr_q[bus.evict_set] + WAY_BITS'(1);
        end
    end

    assign bus.tags_buf      = tagsBuf_q;
    assign bus.states_buf    = statesBuf_q;
    assign bus.evict_way_buf = evictWay_q;

endmodule

// File: tb/tb_l2_set_read.sv
// ---------------------------------------------------------------------------
// tb_l2_set_read
// Directed bench for l2_set_read. Inputs change on the falling clock edge and
// outputs are sampled 1 time unit later, well away from the rising edge.
// ---------------------------------------------------------------------------
module tb_l2_set_read;
    localparam int WAYS       = 4;
    localparam int WORDS      = 4;
    localparam int SET_BITS   = 8;
    localparam int TAG_BITS   = 20;
    localparam int STATE_BITS = 3;
    localparam int LINE_BITS  = WORDS * STATE_BITS;

    localparam logic [WAYS*TAG_BITS-1:0]  TAGS_A   = {20'h44444, 20'hABCDE, 20'h22222, 20'h11111};
    localparam logic [WAYS*TAG_BITS-1:0]  TAGS_B   = {20'h00001, 20'hBBBBB, 20'hCCCCC, 20'hDDDDD};
    localparam logic [WAYS*TAG_BITS-1:0]  TAGS_AW  = {20'h00001, 20'hABCDE, 20'h22222, 20'h11111};
    localparam logic [WAYS*LINE_BITS-1:0] STATES_A  = 48'h123456707654;
    localparam logic [WAYS*LINE_BITS-1:0] STATES_B  = 48'h765432101234;
    localparam logic [WAYS*LINE_BITS-1:0] STATES_AW = 48'h249456707654;
    localparam logic [LINE_BITS-1:0]      STATES_W  = 12'h249;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checkCount = 0;
    int   passCount  = 0;

    l2_set_read_if #(
        .WAYS(WAYS), .WORDS(WORDS), .SET_BITS(SET_BITS),
        .TAG_BITS(TAG_BITS), .STATE_BITS(STATE_BITS)
    ) bus ();

    l2_set_read #(
        .WAYS(WAYS), .WORDS(WORDS), .SET_BITS(SET_BITS),
        .TAG_BITS(TAG_BITS), .STATE_BITS(STATE_BITS)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic nextCycle;
        @(negedge clk);
    endtask

    task automatic clearInputs;
        bus.req_valid   = 1'b0;
        bus.req_set     = '0;
        bus.rd_tags     = '0;
        bus.rd_states   = '0;
        bus.wr_en       = 1'b0;
        bus.wr_set      = '0;
        bus.wr_way      = '0;
        bus.wr_tag      = '0;
        bus.wr_states   = '0;
        bus.evict_adv   = 1'b0;
        bus.evict_set   = '0;
        bus.lookup_done = 1'b0;
    endtask

    // Drives a request for one cycle and leaves us at the WAIT-cycle falling edge.
    task automatic startRequest(input logic [SET_BITS-1:0] s);
        bus.req_valid = 1'b1;
        bus.req_set   = s;
        nextCycle;
        bus.req_valid = 1'b0;
    endtask

    // From the LOOKUP-cycle falling edge: one HOLD cycle, then release.
    task automatic finishRequest;
        nextCycle;
        bus.lookup_done = 1'b1;
        nextCycle;
        bus.lookup_done = 1'b0;
    endtask

    task automatic pulseEvict(input logic [SET_BITS-1:0] s, input int n);
        for (int i = 0; i < n; i++) begin
            bus.evict_adv = 1'b1;
            bus.evict_set = s;
            nextCycle;
        end
        bus.evict_adv = 1'b0;
    endtask

    task automatic test_reset;
        clearInputs;
        rst = 1'b0;
        nextCycle;
        #1;
        checkCount++;
        if (bus.req_ready !== 1'b1) $display("[TB] FAIL reset_req_ready: got %0b expected 1", bus.req_ready); else passCount++;
        checkCount++;
        if (bus.rd_en !== 1'b0) $display("[TB] FAIL reset_rd_en: got %0b expected 0", bus.rd_en); else passCount++;
        checkCount++;
        if (bus.lookup_en !== 1'b0) $display("[TB] FAIL reset_lookup_en: got %0b expected 0", bus.lookup_en); else passCount++;
        checkCount++;
        if (bus.bufs_valid !== 1'b0) $display("[TB] FAIL reset_bufs_valid: got %0b expected 0", bus.bufs_valid); else passCount++;
        checkCount++;
        if (bus.tags_buf !== '0 || bus.states_buf !== '0 || bus.evict_way_buf !== '0)
            $display("[TB] FAIL reset_buffers: got tags %h states %h evict %0d expected all 0", bus.tags_buf, bus.states_buf, bus.evict_way_buf);
        else passCount++;
        rst = 1'b1;
        nextCycle;
    endtask

    task automatic test_basic;
        bus.req_valid = 1'b1;
        bus.req_set   = 8'h12;
        #1;
        checkCount++;
        if (bus.rd_en !== 1'b1 || bus.rd_set !== 8'h12)
            $display("[TB] FAIL basic_rd_cmd: got rd_en %0b rd_set %h expected 1 12", bus.rd_en, bus.rd_set);
        else passCount++;
        nextCycle;
        bus.req_valid   = 1'b0;
        bus.rd_tags     = TAGS_A;
        bus.rd_states   = STATES_A;
        bus.lookup_done = 1'b1;
        #1;
        checkCount++;
        if (bus.lookup_en !== 1'b0 || bus.req_ready !== 1'b0 || bus.rd_en !== 1'b0)
            $display("[TB] FAIL basic_wait: got lookup_en %0b req_ready %0b rd_en %0b expected 0 0 0", bus.lookup_en, bus.req_ready, bus.rd_en);
        else passCount++;
        nextCycle;
        bus.rd_tags = '0;
        #1;
        checkCount++;
        if (bus.lookup_en !== 1'b1 || bus.bufs_valid !== 1'b1)
            $display("[TB] FAIL basic_lookup_cycle2: got lookup_en %0b bufs_valid %0b expected 1 1", bus.lookup_en, bus.bufs_valid);
        else passCount++;
        checkCount++;
        if (bus.tags_buf[2*TAG_BITS +: TAG_BITS] !== 20'hABCDE)
            $display("[TB] FAIL basic_tag_way2: got %h expected abcde", bus.tags_buf[2*TAG_BITS +: TAG_BITS]);
        else passCount++;
        checkCount++;
        if (bus.tags_buf !== TAGS_A || bus.states_buf !== STATES_A)
            $display("[TB] FAIL basic_buffers: got %h / %h expected %h / %h", bus.tags_buf, bus.states_buf, TAGS_A, STATES_A);
        else passCount++;
        nextCycle;
        bus.lookup_done = 1'b0;
        #1;
        checkCount++;
        if (bus.lookup_en !== 1'b0 || bus.bufs_valid !== 1'b1)
            $display("[TB] FAIL basic_hold: got lookup_en %0b bufs_valid %0b expected 0 1", bus.lookup_en, bus.bufs_valid);
        else passCount++;
        nextCycle;
        bus.lookup_done = 1'b1;
        #1;
        checkCount++;
        if (bus.bufs_valid !== 1'b1 || bus.req_ready !== 1'b0)
            $display("[TB] FAIL basic_done_ignored_early: got bufs_valid %0b req_ready %0b expected 1 0", bus.bufs_valid, bus.req_ready);
        else passCount++;
        nextCycle;
        bus.lookup_done = 1'b0;
        #1;
        checkCount++;
        if (bus.req_ready !== 1'b1 || bus.bufs_valid !== 1'b0)
            $display("[TB] FAIL basic_release: got req_ready %0b bufs_valid %0b expected 1 0", bus.req_ready, bus.bufs_valid);
        else passCount++;
    endtask

    task automatic test_evict;
        pulseEvict(8'h05, 4);
        startRequest(8'h05);
        nextCycle;
        #1;
        checkCount++;
        if (bus.evict_way_buf !== 2'd0) $display("[TB] FAIL evict_wrap4: got %0d expected 0", bus.evict_way_buf); else passCount++;
        finishRequest;
        pulseEvict(8'h05, 3);
        startRequest(8'h05);
        nextCycle;
        #1;
        checkCount++;
        if (bus.evict_way_buf !== 2'd3) $display("[TB] FAIL evict_three: got %0d expected 3", bus.evict_way_buf); else passCount++;
        nextCycle;
        bus.evict_adv = 1'b1;
        bus.evict_set = 8'h05;
        nextCycle;
        bus.evict_adv = 1'b0;
        #1;
        checkCount++;
        if (bus.evict_way_buf !== 2'd3) $display("[TB] FAIL evict_stable_hold: got %0d expected 3", bus.evict_way_buf); else passCount++;
        bus.lookup_done = 1'b1;
        nextCycle;
        bus.lookup_done = 1'b0;
        pulseEvict(8'h05, 2);
        startRequest(8'h05);
        bus.evict_adv = 1'b1;
        bus.evict_set = 8'h05;
        nextCycle;
        bus.evict_adv = 1'b0;
        #1;
        checkCount++;
        if (bus.evict_way_buf !== 2'd2) $display("[TB] FAIL evict_same_cycle_pre: got %0d expected 2", bus.evict_way_buf); else passCount++;
        finishRequest;
        startRequest(8'h05);
        nextCycle;
        #1;
        checkCount++;
        if (bus.evict_way_buf !== 2'd3) $display("[TB] FAIL evict_same_cycle_post: got %0d expected 3", bus.evict_way_buf); else passCount++;
        finishRequest;
    endtask

    task automatic test_hold_write;
        logic [WAYS*LINE_BITS-1:0] expStates;
        logic [WAYS*TAG_BITS-1:0]  expTags;
        expStates = '1;
        expStates[LINE_BITS +: LINE_BITS] = '0;
        expTags = TAGS_A;
        expTags[TAG_BITS +: TAG_BITS] = 20'h55555;
        startRequest(8'h07);
        bus.rd_tags   = TAGS_A;
        bus.rd_states = '1;
        nextCycle;
        nextCycle;
        bus.wr_en     = 1'b1;
        bus.wr_set    = 8'h08;
        bus.wr_way    = 2'd1;
        bus.wr_tag    = 20'h55555;
        bus.wr_states = '0;
        nextCycle;
        bus.wr_en = 1'b0;
        #1;
        checkCount++;
        if (bus.states_buf !== {(WAYS*LINE_BITS){1'b1}} || bus.tags_buf !== TAGS_A)
            $display("[TB] FAIL hold_write_other_set: got %h / %h expected unchanged", bus.tags_buf, bus.states_buf);
        else passCount++;
        bus.wr_en  = 1'b1;
        bus.wr_set = 8'h07;
        nextCycle;
        bus.wr_en = 1'b0;
        #1;
        checkCount++;
        if (bus.states_buf !== expStates || bus.tags_buf !== expTags)
            $display("[TB] FAIL hold_write_same_set: got %h / %h expected %h / %h", bus.tags_buf, bus.states_buf, expTags, expStates);
        else passCount++;
        bus.lookup_done = 1'b1;
        nextCycle;
        bus.lookup_done = 1'b0;
    endtask

    task automatic test_wait_write;
        startRequest(8'h03);
        bus.rd_tags   = TAGS_A;
        bus.rd_states = STATES_A;
        bus.wr_en     = 1'b1;
        bus.wr_set    = 8'h03;
        bus.wr_way    = 2'd3;
        bus.wr_tag    = 20'h00001;
        bus.wr_states = STATES_W;
`ifdef L2_SET_READ_BYPASS_EN
        #1;
        checkCount++;
        if (bus.rd_en !== 1'b0) $display("[TB] FAIL wait_write_no_reread: got rd_en %0b expected 0", bus.rd_en); else passCount++;
        nextCycle;
        bus.wr_en = 1'b0;
        #1;
        checkCount++;
        if (bus.lookup_en !== 1'b1) $display("[TB] FAIL wait_write_lookup_cycle2: got %0b expected 1", bus.lookup_en); else passCount++;
        checkCount++;
        if (bus.tags_buf !== TAGS_AW || bus.states_buf !== STATES_AW)
            $display("[TB] FAIL wait_write_merge: got %h / %h expected %h / %h", bus.tags_buf, bus.states_buf, TAGS_AW, STATES_AW);
        else passCount++;
`else
        #1;
        checkCount++;
        if (bus.rd_en !== 1'b1 || bus.rd_set !== 8'h03)
            $display("[TB] FAIL wait_write_reread: got rd_en %0b rd_set %h expected 1 03", bus.rd_en, bus.rd_set);
        else passCount++;
        nextCycle;
        bus.wr_en     = 1'b0;
        bus.rd_tags   = TAGS_B;
        bus.rd_states = STATES_B;
        #1;
        checkCount++;
        if (bus.lookup_en !== 1'b0 || bus.bufs_valid !== 1'b0)
            $display("[TB] FAIL wait_write_cycle2: got lookup_en %0b bufs_valid %0b expected 0 0", bus.lookup_en, bus.bufs_valid);
        else passCount++;
        nextCycle;
        #1;
        checkCount++;
        if (bus.lookup_en !== 1'b1) $display("[TB] FAIL wait_write_lookup_cycle3: got %0b expected 1", bus.lookup_en); else passCount++;
        checkCount++;
        if (bus.tags_buf !== TAGS_B || bus.states_buf !== STATES_B)
            $display("[TB] FAIL wait_write_reread_data: got %h / %h expected %h / %h", bus.tags_buf, bus.states_buf, TAGS_B, STATES_B);
        else passCount++;
`endif
        finishRequest;
    endtask

    task automatic test_reset_mid;
        logic sawLookup;
        pulseEvict(8'h09, 2);
        startRequest(8'h09);
        nextCycle;
        nextCycle;
        rst = 1'b0;
        #1;
        checkCount++;
        if (bus.req_ready !== 1'b1 || bus.bufs_valid !== 1'b0 || bus.tags_buf !== '0)
            $display("[TB] FAIL reset_in_hold: got req_ready %0b bufs_valid %0b tags %h expected 1 0 0", bus.req_ready, bus.bufs_valid, bus.tags_buf);
        else passCount++;
        nextCycle;
        rst = 1'b1;
        sawLookup = 1'b0;
        for (int i = 0; i < 4; i++) begin
            nextCycle;
            #1;
            if (bus.lookup_en !== 1'b0 || bus.bufs_valid !== 1'b0) sawLookup = 1'b1;
        end
        checkCount++;
        if (sawLookup !== 1'b0) $display("[TB] FAIL reset_hold_no_lookup: got lookup activity %0b expected 0", sawLookup); else passCount++;
        startRequest(8'h09);
        nextCycle;
        #1;
        checkCount++;
        if (bus.lookup_en !== 1'b1 || bus.evict_way_buf !== 2'd0)
            $display("[TB] FAIL reset_pointers_cleared: got lookup_en %0b evict %0d expected 1 0", bus.lookup_en, bus.evict_way_buf);
        else passCount++;
        finishRequest;
        startRequest(8'h04);
        rst = 1'b0;
        #1;
        checkCount++;
        if (bus.req_ready !== 1'b1) $display("[TB] FAIL reset_in_wait: got req_ready %0b expected 1", bus.req_ready); else passCount++;
        nextCycle;
        rst = 1'b1;
        sawLookup = 1'b0;
        for (int i = 0; i < 4; i++) begin
            nextCycle;
            #1;
            if (bus.lookup_en !== 1'b0 || bus.rd_en !== 1'b0) sawLookup = 1'b1;
        end
        checkCount++;
        if (sawLookup !== 1'b0) $display("[TB] FAIL reset_wait_no_lookup: got activity %0b expected 0", sawLookup); else passCount++;
    endtask

    initial begin
        test_reset;
        test_basic;
        nextCycle;
        test_evict;
        test_hold_write;
        test_wait_write;
        test_reset_mid;
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
